// File: rtl/life_row_engine.sv
// life_row_engine: 3-row Game-of-Life window loaded word by word, emitting the
// next generation of the middle row as a stream of WORD-bit words.

module life_row_engine_cell #(
    parameter logic [8:0] BIRTH_MASK = 9'b000001000,
    parameter logic [8:0] SURV_MASK  = 9'b000001100
) (
    input  logic [2:0] above_i,   // columns c-1, c, c+1
    input  logic [2:0] cur_i,
    input  logic [2:0] below_i,
    output logic       next_o
);
    logic [3:0] n;

    // Count the eight neighbours and apply the birth/survival masks.
    always_comb begin
        n = 4'd0;
        for (int i = 0; i < 3; i++) begin
            n = n + {3'b0, above_i[i]} + {3'b0, below_i[i]};
        end
        n = n + {3'b0, cur_i[0]} + {3'b0, cur_i[2]};
        next_o = cur_i[1] ? SURV_MASK[n] : BIRTH_MASK[n];
    end
endmodule

module life_row_engine #(
    parameter int         COLS       = 640,
    parameter int         WORD       = 16,
    parameter bit         WRAP       = 1'b1,
    parameter logic [8:0] BIRTH_MASK = 9'b000001000,
    parameter logic [8:0] SURV_MASK  = 9'b000001100,
    localparam int        NW         = COLS / WORD,
    localparam int        IW         = (NW > 1) ? $clog2(NW) : 1,
    localparam int        PW         = $clog2(COLS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WORD-1:0] in_word,
    input  logic            start,
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WORD-1:0] out_word,
    output logic [IW-1:0]   out_index,
    output logic            out_last,
    output logic            done,
    output logic [PW-1:0]   row_pop,
    output logic            row_changed
);
    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     load_idx_q, load_idx_d;
    logic [COLS-1:0]   staging_q, staging_d;
    logic [COLS-1:0]   above_q, above_d, cur_q, cur_d, below_q, below_d;
    logic              in_ready_q;
    logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [WORD-1:0]   out_word_q, out_word_d;
    logic [IW-1:0]     out_index_q, out_index_d;
    logic              done_q, done_d, row_changed_q, row_changed_d;
    logic [PW-1:0]     row_pop_q, row_pop_d, pop_acc_q, pop_acc_d;
    logic              chg_acc_q, chg_acc_d;

    logic              start_acc, load_fire, load_last, out_fire;
    logic [COLS+1:0]   pad_a, pad_c, pad_b;
    logic [WORD+1:0]   win_a, win_c, win_b;
    logic [IW-1:0]     comp_idx;
    logic [WORD-1:0]   next_word;
    logic [PW-1:0]     word_pop;

    assign start_acc = start && (state_q != COMPUTE);
    assign load_fire = in_valid && in_ready_q;
    assign load_last = load_fire && (load_idx_q == IW'(NW - 1));
    assign out_fire  = out_valid_q && out_ready;

    // Word staging and window shift; the shift lands on the edge of the completing word.
    always_comb begin
        staging_d  = staging_q;
        above_d    = above_q;
        cur_d      = cur_q;
        below_d    = below_q;
        load_idx_d = load_idx_q;
        if (load_fire) begin
            staging_d[int'(load_idx_q)*WORD +: WORD] = in_word;
            if (load_last) begin
                above_d    = cur_q;
                cur_d      = below_q;
                below_d    = staging_d;
                load_idx_d = '0;
            end else begin
                load_idx_d = load_idx_q + IW'(1);
            end
        end
    end

    // Rows padded with one edge column each side so every word sees its c-1/c+WORD neighbours.
    assign pad_a = {(WRAP ? above_d[0] : 1'b0), above_d, (WRAP ? above_d[COLS-1] : 1'b0)};
    assign pad_c = {(WRAP ? cur_d[0]   : 1'b0), cur_d,   (WRAP ? cur_d[COLS-1]   : 1'b0)};
    assign pad_b = {(WRAP ? below_d[0] : 1'b0), below_d, (WRAP ? below_d[COLS-1] : 1'b0)};

    // Select the word to compute next: word 0 on start, else the following index.
    always_comb begin
        comp_idx = (start_acc || out_last_q) ? '0 : out_index_q + IW'(1);
        win_a    = pad_a[int'(comp_idx)*WORD +: WORD+2];
        win_c    = pad_c[int'(comp_idx)*WORD +: WORD+2];
        win_b    = pad_b[int'(comp_idx)*WORD +: WORD+2];
    end

    for (genvar j = 0; j < WORD; j++) begin : g_cell
        life_row_engine_cell #(
            .BIRTH_MASK (BIRTH_MASK),
            .SURV_MASK  (SURV_MASK)
        ) u_cell (
            .above_i (win_a[j +: 3]),
            .cur_i   (win_c[j +: 3]),
            .below_i (win_b[j +: 3]),
            .next_o  (next_word[j])
        );
    end

    // Live cells in the word currently being handed over.
    always_comb begin
        word_pop = '0;
        for (int i = 0; i < WORD; i++) begin
            word_pop = word_pop + PW'(out_word_q[i]);
        end
    end

    // Controller: loads move IDLE<->LOAD, start enters COMPUTE, last output word leaves it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, LOAD: begin
                if (start)          state_d = COMPUTE;
                else if (load_fire) state_d = load_last ? IDLE : LOAD;
            end
            COMPUTE: begin
                if (out_fire && out_last_q) state_d = (load_idx_q != '0) ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output stream, per-word accumulation and end-of-row summary.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_word_d    = out_word_q;
        out_index_d   = out_index_q;
        out_last_d    = out_last_q;
        done_d        = 1'b0;
        row_pop_d     = row_pop_q;
        row_changed_d = row_changed_q;
        pop_acc_d     = pop_acc_q;
        chg_acc_d     = chg_acc_q;
        if (start_acc) begin
            out_valid_d = 1'b1;
            out_word_d  = next_word;
            out_index_d = '0;
            out_last_d  = (NW == 1);
            pop_acc_d   = '0;
            chg_acc_d   = 1'b0;
        end else if (out_fire) begin
            pop_acc_d = pop_acc_q + word_pop;
            chg_acc_d = chg_acc_q | (out_word_q != cur_q[int'(out_index_q)*WORD +: WORD]);
            if (out_last_q) begin
                out_valid_d   = 1'b0;
                out_last_d    = 1'b0;
                done_d        = 1'b1;
                row_pop_d     = pop_acc_d;
                row_changed_d = chg_acc_d;
            end else begin
                out_index_d = out_index_q + IW'(1);
                out_word_d  = next_word;
                out_last_d  = (out_index_q + IW'(1)) == IW'(NW - 1);
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            load_idx_q    <= '0;
            staging_q     <= '0;
            above_q       <= '0;
            cur_q         <= '0;
            below_q       <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_word_q    <= '0;
            out_index_q   <= '0;
            out_last_q    <= 1'b0;
            done_q        <= 1'b0;
            row_pop_q     <= '0;
            row_changed_q <= 1'b0;
            pop_acc_q     <= '0;
            chg_acc_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_idx_q    <= load_idx_d;
            staging_q     <= staging_d;
            above_q       <= above_d;
            cur_q         <= cur_d;
            below_q       <= below_d;
            in_ready_q    <= (state_d != COMPUTE);
            out_valid_q   <= out_valid_d;
            out_word_q    <= out_word_d;
            out_index_q   <= out_index_d;
            out_last_q    <= out_last_d;
            done_q        <= done_d;
            row_pop_q     <= row_pop_d;
            row_changed_q <= row_changed_d;
            pop_acc_q     <= pop_acc_d;
            chg_acc_q     <= chg_acc_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign busy        = (state_q == COMPUTE);
    assign out_valid   = out_valid_q;
    assign out_word    = out_word_q;
    assign out_index   = out_index_q;
    assign out_last    = out_last_q;
    assign done        = done_q;
    assign row_pop     = row_pop_q;
    assign row_changed = row_changed_q;
endmodule
